// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode issue, writeback, flush and status bundle of the hazard scoreboard
// master drives issue/source/writeback/flush and reads status; slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int INF_BITS  = 6
);
  logic                    issue_valid_i;
  logic                    issue_int_we_i;
  logic [REGI_BITS-1:0]    issue_int_dest_i;
  logic                    issue_vec_we_i;
  logic [VECT_BITS-1:0]    issue_vec_dest_i;
  logic [REGI_BITS-1:0]    src_int1_i;
  logic [REGI_BITS-1:0]    src_int2_i;
  logic [1:0]              src_int_used_i;
  logic [VECT_BITS-1:0]    src_vec1_i;
  logic [VECT_BITS-1:0]    src_vec2_i;
  logic [1:0]              src_vec_used_i;
  logic                    wb_int_we_i;
  logic [REGI_BITS-1:0]    wb_int_dest_i;
  logic                    wb_vec_we_i;
  logic [VECT_BITS-1:0]    wb_vec_dest_i;
  logic                    flush_i;
  logic                    stall_o;
  logic                    issue_ok_o;
  logic [2**REGI_BITS-1:0] int_busy_o;
  logic [2**VECT_BITS-1:0] vec_busy_o;
  logic [INF_BITS-1:0]     inflight_o;
  logic                    draining_o;
  logic                    err_o;
  modport master (
    output issue_valid_i, issue_int_we_i, issue_int_dest_i, issue_vec_we_i, issue_vec_dest_i,
           src_int1_i, src_int2_i, src_int_used_i, src_vec1_i, src_vec2_i, src_vec_used_i,
           wb_int_we_i, wb_int_dest_i, wb_vec_we_i, wb_vec_dest_i, flush_i,
    input  stall_o, issue_ok_o, int_busy_o, vec_busy_o, inflight_o, draining_o, err_o
  );
  modport slave (
    input  issue_valid_i, issue_int_we_i, issue_int_dest_i, issue_vec_we_i, issue_vec_dest_i,
           src_int1_i, src_int2_i, src_int_used_i, src_vec1_i, src_vec2_i, src_vec_used_i,
           wb_int_we_i, wb_int_dest_i, wb_vec_we_i, wb_vec_dest_i, flush_i,
    output stall_o, issue_ok_o, int_busy_o, vec_busy_o, inflight_o, draining_o, err_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters that stall decode on hazards and drain after flush
// Ports: clk, rst (async active-low), bus (hazard_scoreboard_if.slave: issue/source/writeback/flush in, stall/status out).
module hazard_scoreboard #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int CNT_BITS  = 2,
  parameter int INF_BITS  = 6
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  localparam int NI = 2**REGI_BITS;
  localparam int NV = 2**VECT_BITS;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, nxt;
  logic [CNT_BITS-1:0] int_cnt [NI];
  logic [CNT_BITS-1:0] vec_cnt [NV];
  logic [INF_BITS-1:0] inflight;
  logic [NI-1:0] int_busy;
  logic [NV-1:0] vec_busy;
  logic err, draining, hazard, stall, ok;
  logic int_inc, vec_inc, int_dec, vec_dec, int_err, vec_err;
  always_comb begin
    hazard = (bus.src_int_used_i[0] && int_cnt[bus.src_int1_i] != '0) ||
             (bus.src_int_used_i[1] && int_cnt[bus.src_int2_i] != '0) ||
             (bus.src_vec_used_i[0] && vec_cnt[bus.src_vec1_i] != '0) ||
             (bus.src_vec_used_i[1] && vec_cnt[bus.src_vec2_i] != '0) ||
             (bus.issue_int_we_i && int_cnt[bus.issue_int_dest_i] == '1) ||
             (bus.issue_vec_we_i && vec_cnt[bus.issue_vec_dest_i] == '1) ||
             (inflight == '1);
    stall = bus.issue_valid_i && (hazard || state == DRAIN || bus.flush_i);
    ok = bus.issue_valid_i && !stall;
    int_inc = ok && bus.issue_int_we_i;
    vec_inc = ok && bus.issue_vec_we_i;
    // a writeback against an empty counter is an error, never a decrement
    int_dec = bus.wb_int_we_i && int_cnt[bus.wb_int_dest_i] != '0;
    vec_dec = bus.wb_vec_we_i && vec_cnt[bus.wb_vec_dest_i] != '0;
    int_err = bus.wb_int_we_i && int_cnt[bus.wb_int_dest_i] == '0;
    vec_err = bus.wb_vec_we_i && vec_cnt[bus.wb_vec_dest_i] == '0;
    nxt = state == RUN ? (bus.flush_i ? DRAIN : RUN) : (inflight == '0 && !bus.flush_i ? RUN : DRAIN);
    int_busy = '0;
    vec_busy = '0;
    for (int i = 0; i < NI; i++) int_busy[i] = int_cnt[i] != '0;
    for (int i = 0; i < NV; i++) vec_busy[i] = vec_cnt[i] != '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NI; i++) int_cnt[i] <= '0;
      for (int i = 0; i < NV; i++) vec_cnt[i] <= '0;
      inflight <= '0;
      err <= 1'b0;
      state <= RUN;
      draining <= 1'b0;
    end else begin
      // issue and writeback on the same register cancel out
      for (int i = 0; i < NI; i++)
        if ((int_inc && bus.issue_int_dest_i == REGI_BITS'(i)) != (int_dec && bus.wb_int_dest_i == REGI_BITS'(i)))
          int_cnt[i] <= (int_inc && bus.issue_int_dest_i == REGI_BITS'(i)) ? int_cnt[i] + CNT_BITS'(1) : int_cnt[i] - CNT_BITS'(1);
      for (int i = 0; i < NV; i++)
        if ((vec_inc && bus.issue_vec_dest_i == VECT_BITS'(i)) != (vec_dec && bus.wb_vec_dest_i == VECT_BITS'(i)))
          vec_cnt[i] <= (vec_inc && bus.issue_vec_dest_i == VECT_BITS'(i)) ? vec_cnt[i] + CNT_BITS'(1) : vec_cnt[i] - CNT_BITS'(1);
      inflight <= inflight + INF_BITS'(int_inc) + INF_BITS'(vec_inc) - INF_BITS'(int_dec) - INF_BITS'(vec_dec);
      err <= err || int_err || vec_err;
      state <= nxt;
      draining <= nxt == DRAIN;
    end
  assign bus.stall_o = stall;
  assign bus.issue_ok_o = ok;
  assign bus.int_busy_o = int_busy;
  assign bus.vec_busy_o = vec_busy;
  assign bus.inflight_o = inflight;
  assign bus.draining_o = draining;
  assign bus.err_o = err;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.REGI_BITS(4), .VECT_BITS(2), .INF_BITS(6)) bus ();
  hazard_scoreboard #(.REGI_BITS(4), .VECT_BITS(2), .CNT_BITS(2), .INF_BITS(6)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.issue_valid_i = 0; bus.issue_int_we_i = 0; bus.issue_int_dest_i = 0;
    bus.issue_vec_we_i = 0; bus.issue_vec_dest_i = 0;
    bus.src_int1_i = 0; bus.src_int2_i = 0; bus.src_int_used_i = 0;
    bus.src_vec1_i = 0; bus.src_vec2_i = 0; bus.src_vec_used_i = 0;
    bus.wb_int_we_i = 0; bus.wb_int_dest_i = 0; bus.wb_vec_we_i = 0; bus.wb_vec_dest_i = 0;
    bus.flush_i = 0;
  endtask
  initial begin
    rst = 0;
    idle();
    #1;
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_ok", bus.issue_ok_o, 0);
    chk("rst_inflight", bus.inflight_o, 0);
    chk("rst_busy", bus.int_busy_o, 0);
    chk("rst_drain", bus.draining_o, 0);
    chk("rst_err", bus.err_o, 0);
    bus.issue_valid_i = 1; bus.issue_int_we_i = 1; bus.issue_int_dest_i = 3;
    #11;
    chk("first_ok", bus.issue_ok_o, 1);
    rst = 1;
    tick();
    idle();
    chk("first_busy", bus.int_busy_o, 16'h0008);
    chk("first_inflight", bus.inflight_o, 1);
    bus.wb_int_we_i = 1; bus.wb_int_dest_i = 3;
    tick();
    idle();
    chk("wb3_inflight", bus.inflight_o, 0);
    chk("wb3_busy", bus.int_busy_o, 0);
    bus.issue_valid_i = 1; bus.issue_int_we_i = 1; bus.issue_int_dest_i = 5;
    #1;
    chk("r5_ok", bus.issue_ok_o, 1);
    tick();
    bus.issue_int_we_i = 0; bus.src_int1_i = 5; bus.src_int_used_i = 2'b01;
    #1;
    chk("raw_stall", bus.stall_o, 1);
    chk("raw_ok", bus.issue_ok_o, 0);
    tick();
    chk("raw_stall2", bus.stall_o, 1);
    bus.src_int_used_i = 2'b00;
    #1;
    chk("unused_src", bus.stall_o, 0);
    bus.src_int2_i = 5; bus.src_int_used_i = 2'b10;
    #1;
    chk("raw_src2", bus.stall_o, 1);
    bus.wb_int_we_i = 1; bus.wb_int_dest_i = 5;
    #1;
    chk("raw_samecyc_wb", bus.stall_o, 1);
    tick();
    bus.wb_int_we_i = 0;
    #1;
    chk("raw_release", bus.stall_o, 0);
    chk("raw_release_ok", bus.issue_ok_o, 1);
    idle();
    bus.issue_valid_i = 1; bus.issue_int_we_i = 1; bus.issue_int_dest_i = 2;
    tick();
    chk("r2_inflight", bus.inflight_o, 1);
    bus.wb_int_we_i = 1; bus.wb_int_dest_i = 2;
    #1;
    chk("r2_both_ok", bus.issue_ok_o, 1);
    tick();
    idle();
    chk("r2_busy", bus.int_busy_o, 16'h0004);
    chk("r2_inflight_same", bus.inflight_o, 1);
    chk("r2_err", bus.err_o, 0);
    bus.wb_int_we_i = 1; bus.wb_int_dest_i = 2;
    tick();
    idle();
    chk("r2_clear", bus.int_busy_o, 0);
    chk("r2_zero", bus.inflight_o, 0);
    bus.issue_valid_i = 1; bus.issue_vec_we_i = 1; bus.issue_vec_dest_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("v1_ok", bus.issue_ok_o, 1);
      tick();
    end
    chk("v1_busy", bus.vec_busy_o, 4'b0010);
    chk("v1_inflight", bus.inflight_o, 3);
    chk("v1_sat_stall", bus.stall_o, 1);
    bus.wb_vec_we_i = 1; bus.wb_vec_dest_i = 1;
    #1;
    chk("v1_sat_samecyc", bus.stall_o, 1);
    tick();
    bus.wb_vec_we_i = 0;
    #1;
    chk("v1_release", bus.issue_ok_o, 1);
    chk("v1_inflight2", bus.inflight_o, 2);
    idle();
    bus.issue_valid_i = 1; bus.flush_i = 1;
    #1;
    chk("flush_stall", bus.stall_o, 1);
    tick();
    bus.flush_i = 0;
    #1;
    chk("drain_flag", bus.draining_o, 1);
    chk("drain_stall", bus.stall_o, 1);
    bus.wb_vec_we_i = 1; bus.wb_vec_dest_i = 1;
    tick();
    chk("drain_inflight1", bus.inflight_o, 1);
    chk("drain_still", bus.draining_o, 1);
    tick();
    bus.wb_vec_we_i = 0;
    #1;
    chk("drain_inflight0", bus.inflight_o, 0);
    chk("drain_hold", bus.draining_o, 1);
    tick();
    chk("run_resume", bus.draining_o, 0);
    chk("run_stall", bus.stall_o, 0);
    chk("run_ok", bus.issue_ok_o, 1);
    idle();
    bus.wb_int_we_i = 1; bus.wb_int_dest_i = 7;
    #1;
    chk("err_pre", bus.err_o, 0);
    tick();
    idle();
    chk("err_set", bus.err_o, 1);
    chk("err_inflight", bus.inflight_o, 0);
    chk("err_busy", bus.int_busy_o, 0);
    tick();
    chk("err_sticky", bus.err_o, 1);
    bus.issue_valid_i = 1; bus.issue_int_we_i = 1; bus.issue_int_dest_i = 4;
    bus.issue_vec_we_i = 1; bus.issue_vec_dest_i = 0;
    tick();
    idle();
    chk("dual_inflight", bus.inflight_o, 2);
    chk("dual_int_busy", bus.int_busy_o, 16'h0010);
    chk("dual_vec_busy", bus.vec_busy_o, 4'b0001);
    bus.flush_i = 1;
    tick();
    bus.flush_i = 0;
    #1;
    chk("rst_drain_pre", bus.draining_o, 1);
    #2;
    rst = 0;
    #1;
    chk("async_drain", bus.draining_o, 0);
    chk("async_inflight", bus.inflight_o, 0);
    chk("async_int_busy", bus.int_busy_o, 0);
    chk("async_vec_busy", bus.vec_busy_o, 0);
    chk("async_err", bus.err_o, 0);
    rst = 1;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Issue controller between the decode stage and the ID/EX pipe register. It tracks in-flight writes to the integer and vector register files and holds decode (stall) while any operand is still pending. It also drains the pipeline after a flush (jump or end). Writeback ports report completions back to it.

Parameters:
REGI_BITS, 4, integer register index width (2**REGI_BITS registers)
VECT_BITS, 2, vector register index width (2**VECT_BITS registers)
CNT_BITS, 2, width of each per-register pending counter (max 2**CNT_BITS-1 outstanding writes per register)
INF_BITS, 6, width of total in-flight counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
issue_valid_i  in  1  decode presents an instruction this cycle
issue_int_we_i  in  1  instruction writes integer register
issue_int_dest_i  in  REGI_BITS  integer destination
issue_vec_we_i  in  1  instruction writes vector register
issue_vec_dest_i  in  VECT_BITS  vector destination
src_int1_i, src_int2_i  in  REGI_BITS each  integer source indices
src_int_used_i  in  2  bit0/bit1 = src_int1/src_int2 actually read
src_vec1_i, src_vec2_i  in  VECT_BITS each  vector source indices
src_vec_used_i  in  2  bit0/bit1 = src_vec1/src_vec2 actually read
wb_int_we_i  in  1  integer writeback completes
wb_int_dest_i  in  REGI_BITS  integer writeback index
wb_vec_we_i  in  1  vector writeback completes
wb_vec_dest_i  in  VECT_BITS  vector writeback index
flush_i  in  1  discard younger instructions, enter drain
stall_o  out  1  hold decode/PC; insert bubble into ID/EX
issue_ok_o  out  1  instruction accepted this cycle
int_busy_o  out  2**REGI_BITS  per-register pending (counter != 0)
vec_busy_o  out  2**VECT_BITS  per-register pending
inflight_o  out  INF_BITS  total outstanding writes
draining_o  out  1  FSM in DRAIN
err_o  out  1  sticky: writeback to register with zero count

Behaviour:
- Reset (rst=0, async): all counters 0, inflight_o 0, state RUN, err_o 0. stall_o/issue_ok_o are 0 while issue_valid_i is 0.
- FSM states RUN, DRAIN.
  - RUN -> DRAIN when flush_i=1.
  - DRAIN -> RUN when inflight_o==0 and flush_i=0. Evaluated on registered state; takes effect next cycle.
  - Reset mid-DRAIN returns to RUN with all counters cleared.
- hazard = any used source whose counter != 0, OR issue_int_we_i with that dest counter at max, OR issue_vec_we_i with that dest counter at max, OR inflight_o at max.
- stall_o = issue_valid_i & (hazard | state==DRAIN | flush_i). Combinational from registered counters.
- issue_ok_o = issue_valid_i & ~stall_o.
- Same-cycle writeback does not clear a hazard. Stall releases the cycle after the writeback edge, so the regfile write has landed.
- On issue_ok_o: destination counter(s) +1 at the clock edge; inflight_o += number of destinations written (0, 1 or 2).
- On wb_*_we_i: that counter -1 and inflight_o -1, in both states.
- Simultaneous issue and writeback on the same register: counter unchanged. inflight_o is updated by the net sum.
- Writeback to a zero counter: counter stays 0, inflight_o unchanged, err_o set until reset.
- Flush does not clear counters. Flushed instructions already in flight still write back and are counted down. Instructions behind the flush were never issued (stall_o=1 in the flush cycle).
- Latency: issue to busy visible = 1 cycle. Writeback to stall release = 1 cycle.

Test Plan:
- Reset with issue_valid_i=1, no sources used, int dest 3 -> issue_ok_o=1; next cycle int_busy_o[3]=1, inflight_o=1.
- RAW hazard: issue writing int r5, then an instruction reading r5 -> stall_o=1 until the cycle after wb_int_we_i with dest 5; no stall when src_int_used_i=0.
- Same-cycle issue of dest r2 and writeback r2 with count 1 -> count stays 1, inflight_o unchanged, err_o=0.
- Saturation: three issues to vector v1 with no writeback -> fourth issue to v1 stalls; one writeback releases it the following cycle.
- Flush with 2 in flight -> draining_o=1 and all issues stalled; after 2 writebacks inflight_o=0 and RUN resumes one cycle later.
- wb_int_we_i to an idle r7 -> err_o=1 sticky and counters unchanged; rst=0 asserted mid-DRAIN clears everything asynchronously.
